// File: rtl/reset_sequencer_pkg.sv
// Shared types and elaboration-time helpers for the reset sequencer.
package reset_sequencer_pkg;

  // Sequencer states: hold everything, gap before a release, wait for the
  // released domain to report ready, and finished.
  typedef enum logic [1:0] {
    HOLD     = 2'd0,
    GAP      = 2'd1,
    WAIT_RDY = 2'd2,
    DONE     = 2'd3
  } rs_state_t;

  // Index width that never collapses to zero bits for a single stage.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Largest of three values, used to size the shared counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/reset_seq_cnt.sv
// Shared up-counter with synchronous clear and a terminal-value compare.
// The terminal value is supplied per state by the sequencer, so one counter
// serves the hold time, the inter-stage gap and the ready timeout.
module reset_seq_cnt #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic         at_term_o
);

  logic [W-1:0] cnt_q;

  // Clear has priority over count; reset and clear behave identically.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign at_term_o = (cnt_q == term_i);

endmodule

// File: rtl/reset_sequencer.sv
// Releases N_STAGES reset domains one at a time in ascending order, with a
// minimum assertion time, a gap before each release and an optional per-stage
// ready handshake bounded by a timeout. A software request restarts the
// whole sequence without clearing the sticky timeout flag.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int N_STAGES          = 3,
  parameter int MIN_ASSERT_CYCLES = 4,
  parameter int STAGE_GAP_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES    = 8
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_sw_rst_req,
  input  logic [N_STAGES-1:0]                i_stage_ready,
  output logic [N_STAGES-1:0]                o_rst_n,
  output logic                               o_all_released,
  output logic                               o_timeout_err,
  output logic [clog2_min1(N_STAGES)-1:0]    o_stage_idx
);

  localparam int IDX_W = clog2_min1(N_STAGES);
  localparam int CNT_W = $clog2(max3(MIN_ASSERT_CYCLES, STAGE_GAP_CYCLES,
                                     TIMEOUT_CYCLES) + 1);

  // Terminal values: the counter starts at 0, so a wait of N edges ends at N-1.
  localparam logic [CNT_W-1:0] MIN_TERM = CNT_W'(MIN_ASSERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_TERM = CNT_W'(STAGE_GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_TERM  =
    CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_STAGES - 1);

  rs_state_t            state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [N_STAGES-1:0]  rst_n_q, rst_n_d;
  logic                 all_rel_q, all_rel_d;
  logic                 err_q, err_d;

  logic                 cnt_clr;
  logic                 cnt_en;
  logic [CNT_W-1:0]     cnt_term;
  logic                 cnt_at_term;
  logic                 stage_done;

  reset_seq_cnt #(
    .W (CNT_W)
  ) u_cnt (
    .clk_i     (i_clk),
    .rst_i     (i_rst),
    .clr_i     (cnt_clr),
    .en_i      (cnt_en),
    .term_i    (cnt_term),
    .at_term_o (cnt_at_term)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= HOLD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and registered-output logic; a software request overrides
  // whatever the current state decided, except for the error flag.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rst_n_d    = rst_n_q;
    all_rel_d  = all_rel_q;
    err_d      = err_q;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    cnt_term   = MIN_TERM;
    stage_done = 1'b0;

    case (state_q)
      HOLD: begin
        cnt_term = MIN_TERM;
        if (cnt_at_term) begin
          state_d = GAP;
          cnt_clr = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end

      GAP: begin
        cnt_term = GAP_TERM;
        if (cnt_at_term) begin
          rst_n_d[idx_q] = 1'b1;
          state_d        = WAIT_RDY;
          cnt_clr        = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end

      WAIT_RDY: begin
        cnt_term = TO_TERM;
        // Ready is checked before the timeout so a same-edge ready wins.
        if ((TIMEOUT_CYCLES == 0) || i_stage_ready[idx_q]) begin
          stage_done = 1'b1;
        end else if (cnt_at_term) begin
          err_d      = 1'b1;
          stage_done = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end

        if (stage_done) begin
          cnt_clr = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d   = DONE;
            all_rel_d = 1'b1;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = GAP;
          end
        end
      end

      DONE: begin
        // Terminal: released stages are no longer monitored.
      end

      default: begin
        state_d = HOLD;
      end
    endcase

    if (i_sw_rst_req) begin
      state_d   = HOLD;
      idx_d     = '0;
      rst_n_d   = '0;
      all_rel_d = 1'b0;
      cnt_clr   = 1'b1;
      cnt_en    = 1'b0;
    end
  end

  // Output registers; only i_rst clears the sticky timeout flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      idx_q     <= '0;
      rst_n_q   <= '0;
      all_rel_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      rst_n_q   <= rst_n_d;
      all_rel_q <= all_rel_d;
      err_q     <= err_d;
    end
  end

  assign o_rst_n        = rst_n_q;
  assign o_all_released = all_rel_q;
  assign o_timeout_err  = err_q;
  assign o_stage_idx    = idx_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a default-parameter instance and a
// TIMEOUT_CYCLES=0 instance share one clock. Expected output events
// (edge number plus {o_rst_n, o_all_released}) are queued when stimulus is
// driven and popped whenever the DUT outputs change.
module tb_reset_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Default instance signals.
  logic       rst = 1'b1;
  logic       sw  = 1'b0;
  logic [2:0] rdy = 3'b111;
  logic [2:0] rst_n;
  logic       all_rel;
  logic       err;
  logic [1:0] idx;

  // No-timeout instance signals.
  logic       rst2 = 1'b1;
  logic       sw2  = 1'b0;
  logic [2:0] rdy2 = 3'b000;
  logic [2:0] rst_n2;
  logic       all_rel2;
  logic       err2;
  logic [1:0] idx2;

  reset_sequencer dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_sw_rst_req   (sw),
    .i_stage_ready  (rdy),
    .o_rst_n        (rst_n),
    .o_all_released (all_rel),
    .o_timeout_err  (err),
    .o_stage_idx    (idx)
  );

  reset_sequencer #(
    .TIMEOUT_CYCLES (0)
  ) dut_nt (
    .i_clk          (clk),
    .i_rst          (rst2),
    .i_sw_rst_req   (sw2),
    .i_stage_ready  (rdy2),
    .o_rst_n        (rst_n2),
    .o_all_released (all_rel2),
    .o_timeout_err  (err2),
    .o_stage_idx    (idx2)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  int base     = 0;

  logic [19:0] exp_q[$];
  logic [19:0] exp2_q[$];
  bit          mon_en  = 1'b0;
  bit          mon2_en = 1'b0;
  logic [3:0]  prev    = 4'b0;
  logic [3:0]  prev2   = 4'b0;

  function automatic void push_exp(input int e, input logic [3:0] v);
    exp_q.push_back({16'(e), v});
  endfunction

  function automatic void push_exp2(input int e, input logic [3:0] v);
    exp2_q.push_back({16'(e), v});
  endfunction

  // Default instance: every output change must match the next queued event.
  always @(negedge clk) begin
    logic [3:0]  cur;
    logic [19:0] obs;
    logic [19:0] ev;
    cur = {rst_n, all_rel};
    if (mon_en && (cur !== prev)) begin
      obs = {16'(edge_cnt), cur};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL event_unexpected: edge=%0d rst_n/all=%b, required no change",
                 edge_cnt, cur);
      end else begin
        ev = exp_q.pop_front();
        if (obs !== ev) begin
          n_errors++;
          $display("FAIL event: got edge=%0d rst_n/all=%b, required edge=%0d rst_n/all=%b",
                   obs[19:4], obs[3:0], ev[19:4], ev[3:0]);
        end
      end
    end
    prev = cur;
  end

  // No-timeout instance monitor.
  always @(negedge clk) begin
    logic [3:0]  cur;
    logic [19:0] obs;
    logic [19:0] ev;
    cur = {rst_n2, all_rel2};
    if (mon2_en && (cur !== prev2)) begin
      obs = {16'(edge_cnt), cur};
      n_checks++;
      if (exp2_q.size() == 0) begin
        n_errors++;
        $display("FAIL nt_event_unexpected: edge=%0d rst_n/all=%b, required no change",
                 edge_cnt, cur);
      end else begin
        ev = exp2_q.pop_front();
        if (obs !== ev) begin
          n_errors++;
          $display("FAIL nt_event: got edge=%0d rst_n/all=%b, required edge=%0d rst_n/all=%b",
                   obs[19:4], obs[3:0], ev[19:4], ev[3:0]);
        end
      end
    end
    prev2 = cur;
  end

  // ---------------- driver tasks ----------------
  // Holds i_rst for three edges; base is then the last reset edge (edge 0).
  task automatic do_reset();
    @(negedge clk);
    mon_en = 1'b0;
    sw     = 1'b0;
    rst    = 1'b1;
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    base   = edge_cnt;
    mon_en = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rdy = 3'b111;
    do_reset();
    n_checks++;
    if ({rst_n, all_rel, err, idx} !== 7'b0) begin
      n_errors++;
      $display("FAIL reset_state: got rst_n=%b all=%b err=%b idx=%0d, required all zero",
               rst_n, all_rel, err, idx);
    end
    n_checks++;
    if ({rst_n2, all_rel2, err2, idx2} !== 7'b0) begin
      n_errors++;
      $display("FAIL nt_reset_state: got rst_n=%b all=%b err=%b idx=%0d, required all zero",
               rst_n2, all_rel2, err2, idx2);
    end
  endtask

  task automatic test_basic();
    rdy = 3'b111;
    do_reset();
    push_exp(base + 6,  4'b0010);
    push_exp(base + 9,  4'b0110);
    push_exp(base + 12, 4'b1110);
    push_exp(base + 13, 4'b1111);
    repeat (16) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL basic_missing: got %0d events pending, required 0", exp_q.size());
      exp_q.delete();
    end
    n_checks++;
    if ({all_rel, err, idx} !== 4'b1010) begin
      n_errors++;
      $display("FAIL basic_final: got all=%b err=%b idx=%0d, required all=1 err=0 idx=2",
               all_rel, err, idx);
    end
  endtask

  task automatic test_timeout();
    rdy = 3'b101;
    do_reset();
    push_exp(base + 6,  4'b0010);
    push_exp(base + 9,  4'b0110);
    push_exp(base + 19, 4'b1110);
    push_exp(base + 20, 4'b1111);
    repeat (16) @(negedge clk);
    n_checks++;
    if (err !== 1'b0) begin
      n_errors++;
      $display("FAIL timeout_early: got err=%b at edge 16, required 0", err);
    end
    @(negedge clk);
    n_checks++;
    if (err !== 1'b1) begin
      n_errors++;
      $display("FAIL timeout_set: got err=%b at edge 17, required 1", err);
    end
    repeat (8) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL timeout_missing: got %0d events pending, required 0", exp_q.size());
      exp_q.delete();
    end
    n_checks++;
    if ({all_rel, err} !== 2'b11) begin
      n_errors++;
      $display("FAIL timeout_final: got all=%b err=%b, required all=1 err=1", all_rel, err);
    end
  endtask

  // Runs directly after test_timeout, so the sequencer sits in DONE with err=1.
  task automatic test_sw_rst_done();
    rdy  = 3'b111;
    sw   = 1'b1;
    base = edge_cnt;
    push_exp(base + 1,  4'b0000);
    push_exp(base + 7,  4'b0010);
    push_exp(base + 10, 4'b0110);
    push_exp(base + 13, 4'b1110);
    push_exp(base + 14, 4'b1111);
    @(negedge clk);
    sw = 1'b0;
    n_checks++;
    if ({rst_n, all_rel, err, idx} !== 7'b0000100) begin
      n_errors++;
      $display("FAIL sw_done_clear: got rst_n=%b all=%b err=%b idx=%0d, required 000 0 1 0",
               rst_n, all_rel, err, idx);
    end
    repeat (14) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL sw_done_missing: got %0d events pending, required 0", exp_q.size());
      exp_q.delete();
    end
    n_checks++;
    if ({all_rel, err} !== 2'b11) begin
      n_errors++;
      $display("FAIL sw_done_final: got all=%b err=%b, required all=1 err=1", all_rel, err);
    end
  endtask

  task automatic test_sw_rst_hold();
    rdy = 3'b111;
    do_reset();
    n_checks++;
    if (err !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_clears_err: got err=%b, required 0", err);
    end
    push_exp(base + 9,  4'b0010);
    push_exp(base + 12, 4'b0110);
    push_exp(base + 15, 4'b1110);
    push_exp(base + 16, 4'b1111);
    repeat (2) @(negedge clk);
    sw = 1'b1;
    @(negedge clk);
    sw = 1'b0;
    repeat (15) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL sw_hold_missing: got %0d events pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_rst_mid_gap();
    rdy = 3'b111;
    do_reset();
    push_exp(base + 6, 4'b0010);
    push_exp(base + 8, 4'b0000);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({rst_n, all_rel, err, idx} !== 7'b0) begin
      n_errors++;
      $display("FAIL mid_gap_rst: got rst_n=%b all=%b err=%b idx=%0d, required all zero",
               rst_n, all_rel, err, idx);
    end
    repeat (4) @(negedge clk);
    rst  = 1'b0;
    base = edge_cnt;
    push_exp(base + 6,  4'b0010);
    push_exp(base + 9,  4'b0110);
    push_exp(base + 12, 4'b1110);
    push_exp(base + 13, 4'b1111);
    repeat (15) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL mid_gap_missing: got %0d events pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Random ready patterns against a stage-by-stage timing model.
  task automatic test_random_ready();
    for (int it = 0; it < 4; it++) begin
      logic [2:0] rel;
      int t;
      int done_t;
      logic err_exp;
      rdy = 3'($urandom_range(0, 7));
      do_reset();
      rel     = 3'b000;
      err_exp = 1'b0;
      t       = 6;
      done_t  = 0;
      for (int k = 0; k < 3; k++) begin
        rel[k] = 1'b1;
        push_exp(base + t, {rel, 1'b0});
        done_t = t + (rdy[k] ? 1 : 8);
        if (!rdy[k]) err_exp = 1'b1;
        t = done_t + 2;
      end
      push_exp(base + done_t, 4'b1111);
      repeat (done_t + 3) @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
        n_errors++;
        $display("FAIL rand_missing: rdy=%b got %0d events pending, required 0",
                 rdy, exp_q.size());
        exp_q.delete();
      end
      n_checks++;
      if (err !== err_exp) begin
        n_errors++;
        $display("FAIL rand_err: rdy=%b got err=%b, required %b", rdy, err, err_exp);
      end
    end
  endtask

  task automatic test_no_timeout();
    int b2;
    rdy2 = 3'b000;
    @(negedge clk);
    rst2    = 1'b0;
    b2      = edge_cnt;
    mon2_en = 1'b1;
    push_exp2(b2 + 6,  4'b0010);
    push_exp2(b2 + 9,  4'b0110);
    push_exp2(b2 + 12, 4'b1110);
    push_exp2(b2 + 13, 4'b1111);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      n_checks++;
      if (err2 !== 1'b0) begin
        n_errors++;
        $display("FAIL nt_err: got err=%b at edge %0d, required 0", err2, i + 1);
      end
    end
    n_checks++;
    if (exp2_q.size() != 0) begin
      n_errors++;
      $display("FAIL nt_missing: got %0d events pending, required 0", exp2_q.size());
      exp2_q.delete();
    end
    n_checks++;
    if (all_rel2 !== 1'b1) begin
      n_errors++;
      $display("FAIL nt_all_released: got %b, required 1", all_rel2);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_sw_rst_done();
    test_sw_rst_hold();
    test_rst_mid_gap();
    test_random_ready();
    test_no_timeout();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Consumes an already-synchronized reset and releases N_STAGES downstream reset domains one at a time, in fixed order 0 → N_STAGES-1.
- Enforces a minimum assertion time, an inter-stage gap, and an optional per-stage ready handshake with timeout.
- Supports a software-initiated re-reset.
- Sits directly downstream of the per-domain reset synchronizer; its input reset is that synchronizer's output, inverted to active-high.

Parameters:
- N_STAGES, 3, number of sequenced reset outputs (1..16).
- MIN_ASSERT_CYCLES, 4, cycles all outputs stay asserted after i_rst drops or after a software request (≥1).
- STAGE_GAP_CYCLES, 2, cycles waited before each stage's release (≥1).
- TIMEOUT_CYCLES, 8, max cycles waiting for a stage's ready. 0 = no ready check; proceed immediately.
- CNT_W, derived = $clog2(max(MIN_ASSERT_CYCLES, STAGE_GAP_CYCLES, TIMEOUT_CYCLES) + 1), internal counter width.

Ports:
- i_clk, input, 1, clock.
- i_rst, input, 1, synchronous active-high reset.
- i_sw_rst_req, input, 1, single-cycle software re-reset request.
- i_stage_ready, input, N_STAGES, bit k high = domain k reports it is out of reset and alive.
- o_rst_n, output, N_STAGES, active-low reset per domain.
- o_all_released, output, 1, high when all stages are released.
- o_timeout_err, output, 1, sticky flag: some stage timed out waiting for ready.
- o_stage_idx, output, $clog2(N_STAGES) (min 1), index of the stage currently being sequenced.

Behaviour:
- Reset is synchronous, active-high, single clock i_clk.
- While i_rst=1 at a rising edge, registers take:
  - state = HOLD, cnt = 0, o_stage_idx = 0
  - o_rst_n = all 0, o_all_released = 0, o_timeout_err = 0
- All outputs are registered; no combinational path from inputs to outputs.
- States: HOLD, GAP, WAIT_RDY, DONE.
- HOLD: cnt increments each edge. At the edge where cnt == MIN_ASSERT_CYCLES-1: go to GAP, cnt = 0.
- GAP: cnt increments. At the edge where cnt == STAGE_GAP_CYCLES-1: set o_rst_n[idx] = 1, go to WAIT_RDY, cnt = 0.
- WAIT_RDY, in priority order at each edge:
  1. If TIMEOUT_CYCLES == 0, or i_stage_ready[idx] == 1: stage is complete.
  2. Else if cnt == TIMEOUT_CYCLES-1: set o_timeout_err = 1; stage is complete.
  3. Else cnt increments.
- On stage complete:
  - If idx == N_STAGES-1: go to DONE and set o_all_released = 1.
  - Else: idx increments, go to GAP, cnt = 0.
- Ready and timeout on the same edge: ready wins, no error.
- DONE: holds. i_stage_ready is ignored.
- Released stages stay released; a stage dropping its ready later is not monitored.
- i_sw_rst_req=1 at an edge in any state:
  - o_rst_n = all 0, o_all_released = 0, idx = 0, cnt = 0, state = HOLD.
  - In HOLD this restarts the hold count.
  - o_timeout_err is NOT cleared; only i_rst clears it.
- i_rst and i_sw_rst_req together: i_rst wins (identical result, except the err flag is cleared).
- Latency: stage k is released at edge MIN_ASSERT_CYCLES + (k+1)·STAGE_GAP_CYCLES + k, counted from the first edge with i_rst=0 (edge 1). This holds when ready is already high.
- o_rst_n bits only ever transition 0→1 in ascending order, except on a global re-assert.

Decomposition:
- Package reset_sequencer_pkg holds:
  - typedef enum logic [1:0] rs_state_t {HOLD, GAP, WAIT_RDY, DONE}
  - function clog2_min1 for index width
- Sub-module reset_seq_cnt: loadable up-counter with clear and terminal-compare output (inputs: clr, en, term value). Instantiated once and shared across states.

Test Plan:
- Defaults, i_stage_ready = 3'b111, i_rst high for 3 edges then low (edge 1 = first low) → o_rst_n[0] rises after edge 6, [1] after edge 9, [2] after edge 12; o_all_released after edge 13; o_timeout_err = 0.
- Defaults, i_stage_ready[1] held 0, others 1 → stage 1 waits 8 edges; o_timeout_err = 1 and sequencing continues; o_rst_n[2] rises 7 edges later than in the first scenario; o_all_released still reaches 1.
- In DONE with err = 1, pulse i_sw_rst_req for 1 cycle → o_rst_n = 0 on the next edge, o_all_released = 0, o_timeout_err stays 1; full sequence repeats with the same spacing.
- i_sw_rst_req pulsed at edge 3 of HOLD → stage 0 release moves from edge 6 to edge 9.
- i_rst reasserted mid-GAP of stage 1 → next edge: all outputs 0, err 0, state HOLD; no glitch on o_rst_n[2].
- TIMEOUT_CYCLES = 0, i_stage_ready = 0 → sequence timing identical to the first scenario; err never set.
